rf_write_arbiter: RTL

- Writeback-side neighbour of the physical register file. Collects results from NUM_SRC functional-unit writeback streams into per-source FIFOs.
- Each cycle, grants up to NUM_WRITE of them onto the register file write ports.
- Holds back any write whose address matches a same-cycle active read, so the register file never sees a read/write collision.
- Raises a stall request to issue when a write is starved by repeated collisions.

---
 rtl/rf_pkg.sv | 19 +
 rtl/wb_fifo.sv | 48 ++++
 rtl/rf_write_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;

  localparam int WIDTH = 32;
  localparam int SIZE  = 64;
  localparam int AW    = $clog2(SIZE);

  typedef logic [AW-1:0]    rf_addr_t;
  typedef logic [WIDTH-1:0] rf_data_t;

  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
  } wb_req_t;

  // Physical register 0 is hard-wired; writes to it are swallowed at enqueue.
  localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/wb_fifo.sv
// Single-clock FIFO of writeback requests with registered occupancy count.
module wb_fifo
  import rf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  wb_req_t          i_req,
  input  logic             i_pop,
  output wb_req_t          o_head,
  output logic [CNT_W-1:0] o_count
);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // NOTE: storage has no reset; the count gates every read, so stale entries are never used.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_req;
  end

  // Pointers are log2(DEPTH) wide, so natural overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/rf_write_arbiter.sv
// Writeback arbiter: per-source FIFOs, round-robin grant onto RF write ports,
// read-collision hold-off and starvation stall. Define RF_WB_PERF_EN for perf counters.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_SRC     = 6,
  parameter int NUM_WRITE   = 4,
  parameter int NUM_READ    = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int STALL_LIMIT = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_SRC-1:0]                 IN_valid,
  input  logic [NUM_SRC-1:0][AW-1:0]         IN_addr,
  input  logic [NUM_SRC-1:0][WIDTH-1:0]      IN_data,
  output logic [NUM_SRC-1:0]                 OUT_ready,
  input  logic [NUM_READ-1:0]                IN_re,
  input  logic [NUM_READ-1:0][AW-1:0]        IN_raddr,
  output logic [NUM_WRITE-1:0]               OUT_we,
  output logic [NUM_WRITE-1:0][AW-1:0]       OUT_waddr,
  output logic [NUM_WRITE-1:0][WIDTH-1:0]    OUT_wdata,
  output logic                               OUT_stallReq,
`ifdef RF_WB_PERF_EN
  output logic [31:0]                        OUT_perfCollide,
  output logic [31:0]                        OUT_perfFull,
`endif
  output logic                               OUT_empty
);

  localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ST_W  = $clog2(STALL_LIMIT + 1);

  wb_req_t          w_req   [NUM_SRC];
  wb_req_t          w_head  [NUM_SRC];
  logic [CNT_W-1:0] w_count [NUM_SRC];
  logic [NUM_SRC-1:0] w_push, w_pop, w_collide, w_elig;

  logic [NUM_WRITE-1:0]            w_we;
  logic [NUM_WRITE-1:0][AW-1:0]    w_waddr;
  logic [NUM_WRITE-1:0][WIDTH-1:0] w_wdata;
  logic [RR_W-1:0]                 w_last_src;
  logic                            w_any_grant;

  logic [RR_W-1:0] r_rr_ptr;
  logic [ST_W-1:0] r_starve [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_req[g].addr = IN_addr[g];
    assign w_req[g].data = IN_data[g];

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[g]),
      .i_req   (w_req[g]),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_count (w_count[g])
    );
  end

  // Ready looks only at the registered count, so a full FIFO stays closed while it drains.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      OUT_ready[i]  = (w_count[i] != CNT_W'(FIFO_DEPTH));
      w_push[i]     = IN_valid[i] && OUT_ready[i] && (IN_addr[i] != RF_ZERO_ADDR);
      w_collide[i]  = 1'b0;
      if (w_count[i] != '0) begin
        for (int j = 0; j < NUM_READ; j++) begin
          if (IN_re[j] && (IN_raddr[j] == w_head[i].addr)) w_collide[i] = 1'b1;
        end
      end
      w_elig[i] = (w_count[i] != '0) && !w_collide[i];
    end
  end

  // Round-robin scan from r_rr_ptr; ports fill in scan order, same-address heads wait.
  always_comb begin
    int  src;
    int  n_used;
    logic dup;
    w_we        = '0;
    w_waddr     = '0;
    w_wdata     = '0;
    w_pop       = '0;
    w_last_src  = '0;
    w_any_grant = 1'b0;
    n_used      = 0;
    src         = 0;
    dup         = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src = int'(r_rr_ptr) + k;
      if (src >= NUM_SRC) src = src - NUM_SRC;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (s == src && w_elig[s] && n_used < NUM_WRITE) begin
          dup = 1'b0;
          for (int p = 0; p < NUM_WRITE; p++) begin
            if (p < n_used && w_waddr[p] == w_head[s].addr) dup = 1'b1;
          end
          if (!dup) begin
            for (int p = 0; p < NUM_WRITE; p++) begin
              if (p == n_used) begin
                w_we[p]    = 1'b1;
                w_waddr[p] = w_head[s].addr;
                w_wdata[p] = w_head[s].data;
              end
            end
            w_pop[s]    = 1'b1;
            w_last_src  = RR_W'(s);
            w_any_grant = 1'b1;
            n_used      = n_used + 1;
          end
        end
      end
    end
  end

  assign OUT_we    = w_we;
  assign OUT_waddr = w_waddr;
  assign OUT_wdata = w_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_any_grant) begin
      r_rr_ptr <= (w_last_src == RR_W'(NUM_SRC - 1)) ? '0 : w_last_src + 1'b1;
    end
  end

  // Starvation counts only collision-blocked cycles; port contention merely holds the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) r_starve[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_count[i] == '0 || w_pop[i]) begin
          r_starve[i] <= '0;
        end else if (w_collide[i] && r_starve[i] != ST_W'(STALL_LIMIT)) begin
          r_starve[i] <= r_starve[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    OUT_stallReq = 1'b0;
    OUT_empty    = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_starve[i] == ST_W'(STALL_LIMIT)) OUT_stallReq = 1'b1;
      if (w_count[i] != '0)                  OUT_empty    = 1'b0;
    end
  end

`ifdef RF_WB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OUT_perfCollide <= '0;
      OUT_perfFull    <= '0;
    end else begin
      if (|w_collide)  OUT_perfCollide <= OUT_perfCollide + 1'b1;
      if (!(&OUT_ready)) OUT_perfFull  <= OUT_perfFull + 1'b1;
    end
  end
`endif

endmodule
